// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order completion buffer.
// Dispatch allocates entries at the tail, execution marks them done out of order,
// and up to RETIRE_WIDTH done entries leave from the head each cycle as register
// file write packets {value, dest, wr_en}.
// Optional feature: define ROB_FLUSH_EN to add a synchronous flush input that
// empties the buffer and overrides that cycle's alloc, completion and retirement.
module reorder_buffer #(
  parameter int DEPTH        = 16,
  parameter int RETIRE_WIDTH = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                               flush,
`endif
  input  logic                               alloc_valid,
  input  logic [3:0]                         alloc_dest,
  input  logic                               alloc_has_dest,
  output logic                               alloc_ready,
  output logic [$clog2(DEPTH)-1:0]           alloc_tag,
  input  logic                               cmpl_valid,
  input  logic [$clog2(DEPTH)-1:0]           cmpl_tag,
  input  logic [15:0]                        cmpl_value,
  output logic [20:0]                        retire_write_data [RETIRE_WIDTH],
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]  retire_count,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               empty,
  output logic                               full
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam int RC_W  = $clog2(RETIRE_WIDTH + 1);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] has_dest_q;
  logic [3:0]       dest_q  [DEPTH];
  logic [15:0]      value_q [DEPTH];

  logic             flush_i;
  logic             alloc_fire;
  logic             cmpl_fire;
  logic [RC_W-1:0]  ret_n;
  logic [20:0]      ret_pkt [RETIRE_WIDTH];

`ifdef ROB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail;

  // Flush wins over everything; a completion to an unallocated slot is dropped.
  assign alloc_fire = alloc_valid && alloc_ready && !flush_i;
  assign cmpl_fire  = cmpl_valid && valid[cmpl_tag] && !flush_i;

  // Count the contiguous run of valid&done entries starting at head and build their packets.
  always_comb begin
    logic             stop;
    logic [TAG_W-1:0] idx;
    stop  = 1'b0;
    idx   = '0;
    ret_n = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      idx        = head + TAG_W'(j);
      ret_pkt[j] = {value_q[idx], dest_q[idx], has_dest_q[idx]};
      if (!stop && valid[idx] && done[idx] && (CNT_W'(j) < count))
        ret_n = RC_W'(j + 1);
      else
        stop = 1'b1;
    end
  end

  // Pointer, occupancy, per-entry status and registered retirement outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      done         <= '0;
      retire_count <= '0;
      for (int j = 0; j < RETIRE_WIDTH; j++)
        retire_write_data[j] <= '0;
    end else if (flush_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      done         <= '0;
      retire_count <= '0;
      for (int j = 0; j < RETIRE_WIDTH; j++)
        retire_write_data[j] <= '0;
    end else begin
      if (cmpl_fire)
        done[cmpl_tag] <= 1'b1;
      // Retired slots are released after the completion update so they end up clean.
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (RC_W'(j) < ret_n) begin
          valid[head + TAG_W'(j)] <= 1'b0;
          done[head + TAG_W'(j)]  <= 1'b0;
        end
        retire_write_data[j] <= (RC_W'(j) < ret_n) ? ret_pkt[j] : '0;
      end
      // Tail slot is never one being retired: it is free whenever alloc can fire.
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
      end
      retire_count <= ret_n;
      head         <= head + TAG_W'(ret_n);
      tail         <= tail + TAG_W'(alloc_fire);
      count        <= count + CNT_W'(alloc_fire) - CNT_W'(ret_n);
    end
  end

  // Payload storage; contents only matter while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest_q[tail]     <= alloc_dest;
      has_dest_q[tail] <= alloc_has_dest;
    end
    if (cmpl_fire)
      value_q[cmpl_tag] <= cmpl_value;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus for reorder_buffer, checked every cycle
// against a queue-based in-order model plus literal expectations at key points.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int RW    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_dest = '0;
  logic        alloc_has_dest = 1'b0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cmpl_valid = 1'b0;
  logic [3:0]  cmpl_tag = '0;
  logic [15:0] cmpl_value = '0;
  logic [20:0] retire_write_data [RW];
  logic [1:0]  retire_count;
  logic [4:0]  count;
  logic        empty;
  logic        full;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .RETIRE_WIDTH(RW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
`ifdef ROB_FLUSH_EN
    .flush             (flush),
`endif
    .alloc_valid       (alloc_valid),
    .alloc_dest        (alloc_dest),
    .alloc_has_dest    (alloc_has_dest),
    .alloc_ready       (alloc_ready),
    .alloc_tag         (alloc_tag),
    .cmpl_valid        (cmpl_valid),
    .cmpl_tag          (cmpl_tag),
    .cmpl_value        (cmpl_value),
    .retire_write_data (retire_write_data),
    .retire_count      (retire_count),
    .count             (count),
    .empty             (empty),
    .full              (full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // In-order model: a queue of outstanding instructions, oldest first.
  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  dest;
    logic        hd;
    logic        dn;
    logic [15:0] val;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_tail = '0;
  int          m_rc = 0;
  logic [20:0] m_pkt [RW];

  task automatic model_clear();
    q.delete();
    m_tail = '0;
    m_rc   = 0;
    for (int j = 0; j < RW; j++) m_pkt[j] = '0;
  endtask

  task automatic model_edge();
    int   n;
    bit   acc;
    bit   fl;
    ent_t e;
    fl = 1'b0;
`ifdef ROB_FLUSH_EN
    fl = flush;
`endif
    if (fl) begin
      model_clear();
      return;
    end
    n = 0;
    while (n < RW && n < q.size() && q[n].dn) n++;
    for (int j = 0; j < RW; j++)
      m_pkt[j] = (j < n) ? {q[j].val, q[j].dest, q[j].hd} : 21'd0;
    m_rc = n;
    if (cmpl_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].tag == cmpl_tag) begin
          e = q[i];
          e.dn = 1'b1;
          e.val = cmpl_value;
          q[i] = e;
        end
      end
    end
    acc = alloc_valid && (q.size() < DEPTH);
    repeat (n) void'(q.pop_front());
    if (acc) begin
      e.tag  = m_tail;
      e.dest = alloc_dest;
      e.hd   = alloc_has_dest;
      e.dn   = 1'b0;
      e.val  = '0;
      q.push_back(e);
      m_tail = m_tail + 4'd1;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_count", count, q.size());
        chk("m_empty", empty, q.size() == 0);
        chk("m_full", full, q.size() == DEPTH);
        chk("m_alloc_ready", alloc_ready, q.size() < DEPTH);
        chk("m_alloc_tag", alloc_tag, m_tail);
        chk("m_retire_count", retire_count, m_rc);
        for (int j = 0; j < RW; j++)
          chk($sformatf("m_retire_data%0d", j), retire_write_data[j], m_pkt[j]);
      end
    end
  end

  task automatic cyc(input bit av, input logic [3:0] d, input bit hd,
                     input bit cv, input logic [3:0] t, input logic [15:0] v);
    alloc_valid = av; alloc_dest = d; alloc_has_dest = hd;
    cmpl_valid = cv; cmpl_tag = t; cmpl_value = v;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called 1 time unit after a rising edge; reset drops between edges.
  task automatic do_reset(input string tagname);
    #2 rst_n = 1'b0;
    #1;
    chk({tagname, "_rc"}, retire_count, 0);
    for (int j = 0; j < RW; j++)
      chk($sformatf("%s_pkt%0d", tagname, j), retire_write_data[j], 0);
    chk({tagname, "_count"}, count, 0);
    chk({tagname, "_empty"}, empty, 1);
    chk({tagname, "_full"}, full, 0);
    chk({tagname, "_ready"}, alloc_ready, 1);
    chk({tagname, "_tag"}, alloc_tag, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_rc", retire_count, 0);
    chk("rst_pkt0", retire_write_data[0], 0);
    #9 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // three allocs, completed in reverse order, retire together one edge after the last
    cyc(1, 4'd1, 1, 0, 0, 0);
    cyc(1, 4'd2, 1, 0, 0, 0);
    cyc(1, 4'd3, 1, 0, 0, 0);
    chk("a3_count", count, 3);
    cyc(0, 0, 0, 1, 4'd2, 16'h3333);
    cyc(0, 0, 0, 1, 4'd1, 16'h2222);
    cyc(0, 0, 0, 1, 4'd0, 16'h1111);
    chk("latency_rc", retire_count, 0);
    idle(1);
    chk("burst_rc", retire_count, 3);
    chk("burst_pkt0", retire_write_data[0], {16'h1111, 4'd1, 1'b1});
    chk("burst_pkt1", retire_write_data[1], {16'h2222, 4'd2, 1'b1});
    chk("burst_pkt2", retire_write_data[2], {16'h3333, 4'd3, 1'b1});
    chk("burst_empty", empty, 1);
    idle(1);
    chk("hold_rc", retire_count, 0);
    chk("hold_pkt0", retire_write_data[0], 0);

    // out-of-order completion blocks behind an incomplete head
    do_reset("r1");
    for (int i = 0; i < 4; i++) cyc(1, 4'(4 + i), 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd2, 16'hAAAA);
    cyc(0, 0, 0, 1, 4'd0, 16'h0B0B);
    chk("ooo_rc0", retire_count, 0);
    cyc(0, 0, 0, 1, 4'd1, 16'h0C0C);
    chk("ooo_rc1", retire_count, 1);
    chk("ooo_pkt0", retire_write_data[0], {16'h0B0B, 4'd4, 1'b1});
    chk("ooo_pkt1", retire_write_data[1], 0);
    idle(1);
    chk("ooo_rc2", retire_count, 2);
    chk("ooo_pkt0b", retire_write_data[0], {16'h0C0C, 4'd5, 1'b1});
    chk("ooo_pkt1b", retire_write_data[1], {16'hAAAA, 4'd6, 1'b1});
    chk("ooo_count", count, 1);

    // fill to full, reject the 17th, wrap the tail after retiring
    do_reset("r2");
    for (int i = 0; i < 16; i++) cyc(1, 4'(i), 1, 0, 0, 0);
    chk("full_full", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    cyc(1, 4'd15, 1, 0, 0, 0);
    chk("full_17th_count", count, 16);
    cyc(0, 0, 0, 1, 4'd2, 16'h0202);
    cyc(0, 0, 0, 1, 4'd1, 16'h0101);
    cyc(0, 0, 0, 1, 4'd0, 16'h0000);
    cyc(1, 4'd7, 1, 0, 0, 0);
    chk("full_ret_rc", retire_count, 3);
    chk("full_ret_count", count, 13);
    chk("full_ret_ready", alloc_ready, 1);
    chk("full_ret_tag", alloc_tag, 0);
    cyc(1, 4'd7, 1, 0, 0, 0);
    chk("wrap_count", count, 14);
    chk("wrap_tag", alloc_tag, 1);

    // mixed traffic: simultaneous alloc/complete/retire, completions to empty slots
    do_reset("r3");
    for (int i = 0; i < 60; i++)
      cyc((i % 4) != 3, 4'(i), (i % 5) != 0,
          (i % 3) != 1, 4'((i * 5) % 16), 16'(i * 257 + 3));
    idle(3);

    // no-destination instruction still retires, with wr_en low
    do_reset("r4");
    cyc(1, 4'd9, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd0, 16'h5A5A);
    chk("nodest_rc0", retire_count, 0);
    idle(1);
    chk("nodest_rc", retire_count, 1);
    chk("nodest_pkt0", retire_write_data[0], {16'h5A5A, 4'd9, 1'b0});
    chk("nodest_wren", retire_write_data[0][0], 0);

`ifdef ROB_FLUSH_EN
    do_reset("r5");
    for (int i = 0; i < 5; i++) cyc(1, 4'(i), 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd0, 16'h7777);
    flush = 1'b1;
    cyc(1, 4'd3, 1, 1, 4'd1, 16'h8888);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_tag", alloc_tag, 0);
    chk("flush_rc", retire_count, 0);
    chk("flush_pkt0", retire_write_data[0], 0);
    idle(1);
    chk("flush_rc_after", retire_count, 0);
`endif

    // reset asserted between edges while a retirement packet is on the outputs
    do_reset("r6");
    cyc(1, 4'd1, 1, 0, 0, 0);
    cyc(1, 4'd2, 1, 0, 0, 0);
    cyc(1, 4'd3, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd2, 16'h1234);
    cyc(0, 0, 0, 1, 4'd1, 16'h5678);
    cyc(0, 0, 0, 1, 4'd0, 16'h9ABC);
    idle(1);
    chk("mid_rc_before", retire_count, 3);
    do_reset("mid");
    idle(1);
    chk("mid_rc_after", retire_count, 0);
    chk("mid_count_after", count, 0);

    idle(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
